regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the fixed 32x32, 2-read/1-write register file in the single-cycle datapath.
- Adds configurable width, depth and read-port count, an optional hardwired zero register, and a sequential clear engine.
- The clear engine zeroes the array after reset or on request, and reports busy while it runs.
- Instantiated by the datapath between decode and the ALU: combinational reads, clocked writes.

Parameters:
DATA_W, 32, data width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
clr_req  input  1  single-cycle pulse requesting a full array clear
busy  output  1  high while the clear engine runs
wr_drop  output  1  registered pulse: the previous cycle's wr_en was discarded

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at the rising edge of clk.
- Reset effect (rst_n=0 at an edge): state<=CLEAR, clr_cnt<=0, busy<=1, wr_drop<=0. Array contents are not reset directly; they are cleared by the engine.
- FSM states: IDLE and CLEAR.
- CLEAR state:
  - Each cycle writes 0 to reg[clr_cnt], then clr_cnt<=clr_cnt+1.
  - When clr_cnt==DEPTH-1, the 0 is written, state<=IDLE and busy<=0 at that same edge.
  - Clear takes exactly DEPTH cycles; busy is high for DEPTH cycles after the reset edge.
  - clr_req is ignored in CLEAR; it does not restart the count.
- IDLE state:
  - clr_req=1 at an edge: state<=CLEAR, clr_cnt<=0, busy<=1.
  - clr_req has priority over a write in the same cycle; that write is discarded.
- Reset asserted mid-clear: clr_cnt restarts at 0, busy stays 1, and a full DEPTH-cycle clear follows.
- Writes:
  - In IDLE with wr_en=1 and no clr_req: reg[wr_addr]<=wr_data at the rising edge.
  - With ZERO_REG=1 and wr_addr==0, the write is silently ignored. It is not flagged as a drop.
  - wr_en=1 while busy=1, or coinciding with an accepted clr_req: the write is discarded and wr_drop=1 in the following cycle.
- wr_drop: registered, 1-cycle latency, 1-cycle pulse per dropped write; otherwise 0.
- Reads:
  - Purely combinational, zero latency: rd_data[k] = reg[rd_addr[k]].
  - With ZERO_REG=1, rd_addr[k]==0 returns 0 regardless of array contents.
  - While busy=1, every read port returns 0.
  - All ports are independent. Identical addresses on several ports return identical data.
- Same-cycle read and write to the same address: without the optional bypass, the read returns the old value; the new value is visible after the edge.
- Address width: no out-of-range addresses exist, since DEPTH = 2**ADDR_W. clr_cnt is ADDR_W bits wide; the terminal compare prevents wrap.

Optional Feature:
- Macro: REGFILE_MP_WR_BYPASS_EN.
- Defined: when wr_en=1, busy=0, no clr_req, rd_addr[k]==wr_addr, and not (ZERO_REG=1 and wr_addr==0), rd_data[k]=wr_data combinationally in the same cycle (write-through forwarding).
- Not defined: no forwarding; a same-cycle read returns the pre-write value. No extra logic is generated.

Test Plan:
- Reset clear: hold rst_n=0 for 1 edge, release -> busy=1 for exactly 32 cycles (default params), reads return 0 throughout, busy=0 on the 33rd cycle; then read all 32 regs -> all 0.
- Write/readback: write reg i = i+2 for i=1..31, then set rd_addr port0=i, port1=i+1 -> port0=i+2, port1=i+3 (port1 at i=31 wraps to reg0 -> 0); write 0xDEAD to reg0 then read reg0 -> 0, wr_drop stays 0.
- Drop during busy: pulse clr_req, next cycle wr_en=1 wr_addr=7 wr_data=55 -> wr_drop=1 one cycle later; after busy falls, reg7 reads 0.
- Clear priority: in IDLE with reg5=9, assert clr_req and wr_en (addr 5, data 77) in the same cycle -> write discarded, wr_drop pulse, reg5=0 after 32 cycles.
- Reset mid-clear: assert rst_n=0 at clr_cnt=10 -> busy stays high for a further full 32 cycles after release.
- Bypass: write reg3=100, then same-cycle wr_en (addr 3, data 200) with rd_addr=3 -> rd_data=200 with REGFILE_MP_WR_BYPASS_EN defined, 100 without; both builds read 200 on the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired zero register and a sequential clear engine.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_MP_WR_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                busy_q, busy_d;
    logic                wr_drop_q, wr_drop_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                wr_drop_d = wr_en;
                if (clr_cnt_q == '1) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                if (clr_req) begin
                    // A clear request wins over a write arriving in the same cycle.
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                    wr_drop_d = wr_en;
                end else if (wr_en && !wr_zero) begin
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // NOTE: the array has no reset branch; the clear engine zeroes it, keeping it mappable to plain storage.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

`ifdef REGFILE_MP_WR_BYPASS_EN
    logic bypass_ok;
    assign bypass_ok = wr_en && !busy_q && !clr_req && !wr_zero;
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem_q[ra];
`ifdef REGFILE_MP_WR_BYPASS_EN
            if (bypass_ok && (ra == wr_addr)) begin
                rv = wr_data;
            end
`endif
            // Contents are undefined until the clear finishes, so reads are forced to zero while busy.
            if (busy_q || ((ZERO_REG != 0) && (ra == '0))) begin
                rv = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters (32x32, two read ports, zero register).
// Bypass expectations follow REGFILE_MP_WR_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int DEPTH    = 32;
    localparam int BUSY_MAX = 40;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clr_req;
    logic                     busy;
    logic                     wr_drop;

    logic [ADDR_W-1:0]        rd0, rd1;
    logic [DATA_W-1:0]        q0, q1;

    int n_checks = 0;
    int n_fail   = 0;

    assign rd_addr = {rd1, rd0};
    assign q0      = rd_data[DATA_W-1:0];
    assign q1      = rd_data[2*DATA_W-1:DATA_W];

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .clr_req(clr_req),
        .busy   (busy),
        .wr_drop(wr_drop)
    );

    // Performs one accepted write and returns 1 time unit after the following falling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
    endtask

    // Counts consecutive samples with busy high, starting at the current sample point; bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < BUSY_MAX) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd0 = '0; rd1 = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < BUSY_MAX; c++) begin
            rd0 = c[ADDR_W-1:0];
            rd1 = 5'd31 - c[ADDR_W-1:0];
            #1;
            if (busy !== 1'b1) break;
            cnt++;
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL reset_busy_read cycle %0d: got %0h expected 0", c, rd_data);
            end
            @(negedge clk);
        end
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_drop: got %b expected 0", wr_drop);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd0 = i[ADDR_W-1:0];
            rd1 = 5'd31 - i[ADDR_W-1:0];
            #1;
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL reset_clear_read reg %0d: got %0h expected 0", i, rd_data);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [DATA_W-1:0] exp1;
        for (int i = 1; i < DEPTH; i++) begin
            do_write(i[ADDR_W-1:0], DATA_W'(i + 2));
        end
        for (int i = 1; i < DEPTH; i++) begin
            rd0 = i[ADDR_W-1:0];
            rd1 = rd0 + 5'd1;
            exp1 = (i == DEPTH - 1) ? '0 : DATA_W'(i + 3);
            #1;
            n_checks++;
            if (q0 !== DATA_W'(i + 2)) begin
                n_fail++;
                $display("FAIL readback_p0 reg %0d: got %0d expected %0d", i, q0, i + 2);
            end
            n_checks++;
            if (q1 !== exp1) begin
                n_fail++;
                $display("FAIL readback_p1 reg %0d: got %0d expected %0d", rd1, q1, exp1);
            end
        end
        do_write(5'd0, 32'hDEAD);
        rd0 = 5'd0; rd1 = 5'd0;
        #1;
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL zero_reg_read: got %0h expected 0", rd_data);
        end
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_no_drop: got %b expected 0", wr_drop);
        end
    endtask

    task automatic test_drop_busy();
        int cnt;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd55;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_busy_start: got %b expected 1", busy);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (wr_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_busy_pulse: got %b expected 1", wr_drop);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_busy_pulse_end: got %b expected 0", wr_drop);
        end
        count_busy(cnt);
        n_checks++;
        if (cnt != DEPTH - 2) begin
            n_fail++;
            $display("FAIL drop_busy_remaining: got %0d cycles expected %0d", cnt, DEPTH - 2);
        end
        rd0 = 5'd7; rd1 = 5'd8;
        #1;
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL drop_busy_reg7_8: got %0h expected 0", rd_data);
        end
    endtask

    task automatic test_clear_priority();
        int cnt;
        do_write(5'd5, 32'd9);
        rd0 = 5'd5; rd1 = 5'd5;
        #1;
        n_checks++;
        if (q0 !== 32'd9) begin
            n_fail++;
            $display("FAIL prio_pre_read: got %0d expected 9", q0);
        end
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd77;
        @(negedge clk);
        clr_req = 1'b0; wr_en = 1'b0;
        #1;
        n_checks++;
        if (wr_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_wr_drop: got %b expected 1", wr_drop);
        end
        count_busy(cnt);
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++;
            $display("FAIL prio_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        #1;
        n_checks++;
        if (q0 !== '0) begin
            n_fail++;
            $display("FAIL prio_reg5: got %0d expected 0", q0);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_write(5'd20, 32'd1234);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(cnt);
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++;
            $display("FAIL midrst_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        rd0 = 5'd20; rd1 = 5'd10;
        #1;
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear_read: got %0h expected 0", rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_same;
`ifdef REGFILE_MP_WR_BYPASS_EN
        exp_same = 32'd200;
`else
        exp_same = 32'd100;
`endif
        do_write(5'd3, 32'd100);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd200;
        rd0 = 5'd3; rd1 = 5'd3;
        #1;
        n_checks++;
        if (q0 !== exp_same) begin
            n_fail++;
            $display("FAIL bypass_same_p0: got %0d expected %0d", q0, exp_same);
        end
        n_checks++;
        if (q1 !== exp_same) begin
            n_fail++;
            $display("FAIL bypass_same_p1: got %0d expected %0d", q1, exp_same);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (q0 !== 32'd200 || q1 !== 32'd200) begin
            n_fail++;
            $display("FAIL bypass_next: got %0d/%0d expected 200/200", q0, q1);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd5;
        rd0 = 5'd0; rd1 = 5'd3;
        #1;
        n_checks++;
        if (q0 !== '0) begin
            n_fail++;
            $display("FAIL bypass_zero_reg: got %0d expected 0", q0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (q0 !== '0 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_zero_after: got %0d drop %b expected 0 drop 0", q0, wr_drop);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_drop_busy();
        test_clear_priority();
        test_reset_mid();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
